// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Purpose  : Pipelined carry-lookahead adder/subtractor. A DATA_WIDTH add is
//            cut into STAGES slices; each slice is built from BLOCK_WIDTH-bit
//            generate/propagate groups joined by a group-level lookahead. The
//            carry between slices is registered. A single global advance
//            signal moves the whole pipe, giving valid/ready backpressure.
// Ports    : i_clk, i_rst        clock, synchronous active-high reset
//            i_valid/o_in_ready  input handshake
//            i_data_one/two      operands A and B
//            i_carry, i_sub      carry-in, 0 = A+B+cin / 1 = A-B
//            o_valid/i_out_ready output handshake
//            o_data, o_carry     result and carry out of the MSB
//            o_overflow          two's-complement signed overflow
// Revision : 1.0  initial release
// ============================================================================
module pipelined_cla_adder #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 4,
  parameter int STAGES      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_data_one,
  input  logic [DATA_WIDTH-1:0] i_data_two,
  input  logic                  i_carry,
  input  logic                  i_sub,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_carry,
  output logic                  o_overflow
);

  localparam int SLICE_W = DATA_WIDTH / STAGES;
  localparam int GROUPS  = SLICE_W / BLOCK_WIDTH;
  localparam int MSB     = DATA_WIDTH - 1;

  // Lookahead carry into position n of a generate/propagate vector:
  //   c[n] = OR_{i<n} (g[i] & p[i+1] & ... & p[n-1]) | (p[0] & ... & p[n-1] & c0)
  // Written as a flat sum of products so no carry ripples position to position.
  function automatic logic carry_la(input logic [SLICE_W-1:0] g,
                                    input logic [SLICE_W-1:0] p,
                                    input logic               c0,
                                    input int                 n);
    logic acc;
    logic term;
    acc = 1'b0;
    for (int i = 0; i < SLICE_W; i++) begin
      if (i < n) begin
        term = g[i];
        for (int m = 0; m < SLICE_W; m++) begin
          if ((m > i) && (m < n)) term = term & p[m];
        end
        acc = acc | term;
      end
    end
    term = c0;
    for (int m = 0; m < SLICE_W; m++) begin
      if (m < n) term = term & p[m];
    end
    return acc | term;
  endfunction

  // Subtraction is A + ~B + 1; i_carry toggles the effective carry-in.
  logic [DATA_WIDTH-1:0] b_eff;
  logic                  cin_eff;
  assign b_eff   = i_sub ? ~i_data_two : i_data_two;
  assign cin_eff = i_carry ^ i_sub;

  // Per-stage state. a_q/b_q are the operand skew registers, s_q the deskew
  // register holding result bits already produced, c_q the inter-slice carry.
  logic [STAGES-1:0][DATA_WIDTH-1:0] a_q;
  logic [STAGES-1:0][DATA_WIDTH-1:0] b_q;
  logic [STAGES-1:0][DATA_WIDTH-1:0] s_q;
  logic [STAGES-1:0]                 c_q;
  logic [STAGES-1:0]                 v_q;
  logic                              ovf_q;
  logic                              ovf_d;

  logic [STAGES-1:0][SLICE_W-1:0]    slice_sum;
  logic [STAGES-1:0]                 slice_cout;

  logic adv;
  logic accept;
  assign adv        = ~v_q[STAGES-1] | i_out_ready;
  assign o_in_ready = adv & ~i_rst;
  assign accept     = i_valid & o_in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE_W-1:0] op_a;
    logic [SLICE_W-1:0] op_b;
    logic               op_c;
    logic [SLICE_W-1:0] bg;
    logic [SLICE_W-1:0] bp;
    logic [SLICE_W-1:0] gv;
    logic [SLICE_W-1:0] pv;
    logic [SLICE_W-1:0] ggv;
    logic [SLICE_W-1:0] gpv;
    logic [GROUPS-1:0]  grp_g;
    logic [GROUPS-1:0]  grp_p;
    logic [GROUPS:0]    grp_c;
    logic [SLICE_W-1:0] sum;

    if (k == 0) begin : g_head
      assign op_a = i_data_one[SLICE_W-1:0];
      assign op_b = b_eff[SLICE_W-1:0];
      assign op_c = cin_eff;
    end else begin : g_tail
      assign op_a = a_q[k-1][k*SLICE_W +: SLICE_W];
      assign op_b = b_q[k-1][k*SLICE_W +: SLICE_W];
      assign op_c = c_q[k-1];
    end

    always_comb begin
      bg    = op_a & op_b;
      bp    = op_a ^ op_b;
      gv    = '0;
      pv    = '0;
      ggv   = '0;
      gpv   = '0;
      grp_g = '0;
      grp_p = '0;
      grp_c = '0;
      sum   = '0;
      // Group generate/propagate.
      for (int j = 0; j < GROUPS; j++) begin
        gv = '0;
        pv = '0;
        gv[BLOCK_WIDTH-1:0] = bg[j*BLOCK_WIDTH +: BLOCK_WIDTH];
        pv[BLOCK_WIDTH-1:0] = bp[j*BLOCK_WIDTH +: BLOCK_WIDTH];
        grp_g[j] = carry_la(gv, pv, 1'b0, BLOCK_WIDTH);
        grp_p[j] = &pv[BLOCK_WIDTH-1:0];
      end
      // Group-level lookahead across the slice.
      ggv[GROUPS-1:0] = grp_g;
      gpv[GROUPS-1:0] = grp_p;
      for (int j = 0; j <= GROUPS; j++) begin
        grp_c[j] = carry_la(ggv, gpv, op_c, j);
      end
      // Bit carries inside each group, seeded by that group's carry-in.
      for (int j = 0; j < GROUPS; j++) begin
        gv = '0;
        pv = '0;
        gv[BLOCK_WIDTH-1:0] = bg[j*BLOCK_WIDTH +: BLOCK_WIDTH];
        pv[BLOCK_WIDTH-1:0] = bp[j*BLOCK_WIDTH +: BLOCK_WIDTH];
        for (int t = 0; t < BLOCK_WIDTH; t++) begin
          sum[j*BLOCK_WIDTH + t] = bp[j*BLOCK_WIDTH + t] ^ carry_la(gv, pv, grp_c[j], t);
        end
      end
    end

    assign slice_sum[k]  = sum;
    assign slice_cout[k] = grp_c[GROUPS];
  end

  // Overflow needs the operand sign bits as seen by the final slice.
  logic a_msb;
  logic b_msb;
  if (STAGES == 1) begin : g_ovf_direct
    assign a_msb = i_data_one[MSB];
    assign b_msb = b_eff[MSB];
  end else begin : g_ovf_skew
    assign a_msb = a_q[STAGES-2][MSB];
    assign b_msb = b_q[STAGES-2][MSB];
  end
  assign ovf_d = (a_msb == b_msb) && (slice_sum[STAGES-1][SLICE_W-1] != a_msb);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q[0]              <= accept;
      a_q[0]              <= i_data_one;
      b_q[0]              <= b_eff;
      s_q[0]              <= '0;
      s_q[0][SLICE_W-1:0] <= slice_sum[0];
      c_q[0]              <= slice_cout[0];
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]                        <= v_q[k-1];
        a_q[k]                        <= a_q[k-1];
        b_q[k]                        <= b_q[k-1];
        s_q[k]                        <= s_q[k-1];
        s_q[k][k*SLICE_W +: SLICE_W]  <= slice_sum[k];
        c_q[k]                        <= slice_cout[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign o_valid    = v_q[STAGES-1];
  assign o_data     = s_q[STAGES-1];
  assign o_carry    = c_q[STAGES-1];
  assign o_overflow = ovf_q;

  // Consumed operand bits and the last stage's skew copy are never read.
  logic unused_skew_bits;
  assign unused_skew_bits = ^{a_q, b_q};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_cla_adder
// Purpose  : Self-checking bench for pipelined_cla_adder. A behavioural model
//            computes each result with plain wide arithmetic and tracks it
//            through a fixed-length queue of STAGES entries that advances
//            whenever its output slot is empty or being drained.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_cla_adder;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          i_carry;
  logic          i_sub;
  logic          o_valid;
  logic          i_out_ready;
  logic [DW-1:0] o_data;
  logic          o_carry;
  logic          o_overflow;

  always #5 clk = ~clk;

  pipelined_cla_adder #(
    .DATA_WIDTH (DW),
    .BLOCK_WIDTH(BW),
    .STAGES     (ST)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .i_data_one (a),
    .i_data_two (b),
    .i_carry    (i_carry),
    .i_sub      (i_sub),
    .o_valid    (o_valid),
    .i_out_ready(i_out_ready),
    .o_data     (o_data),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
  );

  typedef struct packed {
    logic          v;
    logic          ovf;
    logic          c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t pipe[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   out_count;
  bit   last_accept;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the full-width sum of A, the effective B and the effective carry.
  function automatic ent_t ref_op(input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                                  input logic rc, input logic rs);
    ent_t          r;
    logic [DW-1:0] bb;
    logic [DW:0]   full;
    bb    = rs ? ~rb : rb;
    full  = {1'b0, ra} + {1'b0, bb} + {{DW{1'b0}}, rc ^ rs};
    r.v   = 1'b1;
    r.d   = full[DW-1:0];
    r.c   = full[DW];
    r.ovf = (ra[DW-1] == bb[DW-1]) && (r.d[DW-1] != ra[DW-1]);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] w;
    logic [DW-1:0] c;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       c = '0;
      1:       c = '1;
      2:       c = {1'b0, {(DW-1){1'b1}}};
      3:       c = {1'b1, {(DW-1){1'b0}}};
      default: c = w[DW-1:0];
    endcase
    return c;
  endfunction

  // One clock: compare DUT against the model on the falling edge, advance the
  // model with the inputs present, then return just after the rising edge.
  task automatic cycle();
    ent_t head;
    ent_t nxt;
    bit   m_in_ready;
    @(negedge clk);
    head = pipe[ST-1];
    check_eq("o_valid", {127'b0, o_valid}, {127'b0, head.v});
    if (head.v)
      check_eq("result", {o_overflow, o_carry, o_data}, {head.ovf, head.c, head.d});
    m_in_ready = !rst && (!head.v || i_out_ready);
    check_eq("in_ready", {127'b0, o_in_ready}, {127'b0, m_in_ready});
    last_accept = i_valid && m_in_ready;
    if (head.v && i_out_ready && !rst) out_count++;
    if (rst) begin
      for (int i = 0; i < ST; i++) pipe[i] = '0;
    end else if (!head.v || i_out_ready) begin
      nxt   = ref_op(a, b, i_carry, i_sub);
      nxt.v = last_accept;
      void'(pipe.pop_back());
      pipe.push_front(nxt);
    end
    @(posedge clk);
    #1;
  endtask

  // Single isolated operation; measures edges from drive to o_valid.
  task automatic run_single(input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                            input logic rc, input logic rs);
    int n;
    a = ra; b = rb; i_carry = rc; i_sub = rs;
    i_valid = 1'b1; i_out_ready = 1'b1;
    cycle();
    check_eq("accepted", {127'b0, last_accept}, 128'd1);
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 20) begin
      cycle();
      n++;
    end
    check_eq("latency", n, ST);
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] va [6];
    logic [DW-1:0] vb [6];
    logic          vc [6];
    logic          vs [6];
    int            sent;
    int            cyc;

    for (int i = 0; i < ST; i++) pipe.push_back('0);
    out_count = 0;
    rst = 1'b1; i_valid = 1'b0; i_out_ready = 1'b1;
    a = '0; b = '0; i_carry = 1'b0; i_sub = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset_out", {o_valid, o_overflow, o_carry, o_data}, '0);
    cycle();
    rst = 1'b0;
    cycle();

    // Directed vectors: plain add, carry out, carry through every slice,
    // subtract with borrow, overflow by operand, overflow by carry-in.
    va[0] = 32'h0000_12fc; vb[0] = 32'h75ca_0112; vc[0] = 0; vs[0] = 0;
    va[1] = 32'hd7c8_12ea; vb[1] = 32'hf200_0105; vc[1] = 0; vs[1] = 0;
    va[2] = 32'h0000_000f; vb[2] = 32'hffff_fff1; vc[2] = 0; vs[2] = 0;
    va[3] = 32'h0000_0005; vb[3] = 32'h0000_000a; vc[3] = 0; vs[3] = 1;
    va[4] = 32'h7fff_ffff; vb[4] = 32'h0000_0001; vc[4] = 0; vs[4] = 0;
    va[5] = 32'h7fff_ffff; vb[5] = 32'h0000_0000; vc[5] = 1; vs[5] = 0;
    for (int i = 0; i < 6; i++) run_single(va[i], vb[i], vc[i], vs[i]);

    // Back-to-back stream of 10 with a 3-cycle downstream stall.
    out_count = 0; sent = 0; cyc = 0;
    a = rnd_word(); b = rnd_word(); i_carry = 1'($urandom); i_sub = 1'($urandom);
    while (sent < 10 && cyc < 100) begin
      i_valid     = 1'b1;
      i_out_ready = !(cyc >= 4 && cyc < 7);
      cycle();
      cyc++;
      if (last_accept) begin
        sent++;
        a = rnd_word(); b = rnd_word(); i_carry = 1'($urandom); i_sub = 1'($urandom);
      end
    end
    i_valid = 1'b0; i_out_ready = 1'b1;
    cyc = 0;
    while (out_count < 10 && cyc < 20) begin
      cycle();
      cyc++;
    end
    check_eq("bp_count", out_count, 10);

    // Reset with two operations in flight: both must vanish.
    out_count = 0;
    i_out_ready = 1'b1;
    a = rnd_word(); b = rnd_word(); i_valid = 1'b1;
    cycle();
    a = rnd_word(); b = rnd_word();
    cycle();
    i_out_ready = 1'b0; rst = 1'b1; a = rnd_word();
    cycle();
    rst = 1'b0; i_valid = 1'b0; i_out_ready = 1'b1;
    check_eq("rst_flush_valid", {127'b0, o_valid}, 128'd0);
    for (int i = 0; i < 4; i++) cycle();
    check_eq("rst_flush_count", out_count, 0);
    run_single(32'h1234_5678, 32'h0fed_cba9, 1'b1, 1'b0);

    // Random mixed add/sub traffic with random backpressure and one reset.
    for (int i = 0; i < 400; i++) begin
      i_valid     = ($urandom_range(0, 3) != 0);
      i_out_ready = ($urandom_range(0, 3) != 0);
      rst         = (i == 200);
      a = rnd_word(); b = rnd_word();
      i_carry = 1'($urandom); i_sub = 1'($urandom);
      cycle();
    end
    rst = 1'b0; i_valid = 1'b0; i_out_ready = 1'b1;
    for (int i = 0; i < ST + 2; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
